sample_stash: RTL and testbench
===============================

// Module: sample_stash
// PURPOSE
// - Circular store of the last DEPTH 8-bit samples (stopwatch lap/split memory) with a browse pointer.
// - A new sample is written and displayed immediately; next_sample steps the display through stored entries.
// - Sits between the time-capture logic and the display driver.
// PARAMETERS
// - DEPTH  10  number of 8-bit entries (>=2); pointers are $clog2(DEPTH) bits wide
// PORTS
// - clk              in   1  clock; all state changes on posedge
// - reset            in   1  synchronous, active-high reset
// - sample_in        in   8  sample to store
// - sample_in_valid  in   1  one-cycle write strobe
// - next_sample      in   1  one-cycle browse strobe: advance display pointer
// - sample_out       out  8  registered entry at the display pointer
// BEHAVIOUR
// - State: mem[0..DEPTH-1] (8b each), wr_ptr, show_ptr, sample_out register.
// - Reset (sync, high): all mem entries cleared to 0, wr_ptr=0, show_ptr=0, sample_out=0.
//   Reset overrides every other input; reset mid-stream discards all stored samples.
// - Priority at a posedge: reset > sample_in_valid > next_sample > hold.
// - Write (sample_in_valid=1): mem[wr_ptr]<=sample_in; show_ptr<=wr_ptr;
//   wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1; sample_out<=sample_in.
//   A simultaneous next_sample is ignored.
// - Full buffer: no full flag, no stall; the write at wr_ptr overwrites the oldest entry.
// - Browse (next_sample=1, sample_in_valid=0): show_ptr<=(show_ptr==DEPTH-1)?0:show_ptr+1;
//   sample_out<=mem[new show_ptr]. Wraps DEPTH-1 -> 0 and walks all DEPTH slots,
//   including never-written slots, which read 0.
// - Hold: all state unchanged; sample_out equals mem[show_ptr].
// - Latency: sample_out reflects a write or browse strobe on the same posedge
//   (valid just after the edge, one register stage, no extra cycle).
// - No empty/full outputs; strobes held high for N cycles act N times.
// CONFIGURATION
// - Macro STASH_FILL_COUNT_EN.
//   Defined: adds output fill_count [$clog2(DEPTH+1)-1:0].
//   fill_count = number of written entries since reset; +1 per write; saturates at DEPTH; reset to 0.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
// - Package stash_pkg: localparam SAMPLE_W=8; ptr-width function (clog2).
// - Sub-module stash_ptr_wrap: modulo-DEPTH pointer register with sync clear and inc strobe.
//   Instantiated twice, once for wr_ptr and once for show_ptr.
// - Top: memory register array (reset-clearable) plus the output register and priority mux.
// TESTING (DEPTH=10, inputs driven at negedge, check 1 ns after posedge)
// - Reset 3 cycles -> sample_out=00; browse 10 times -> 00 each step.
// - Write A0..AB (12 samples, one per 2 cycles) -> sample_out equals each sample on its write edge.
//   Slots 0,1 now hold AA,AB.
// - Write with next_sample also high (3rd write, A2) -> sample_out=A2; show_ptr is not advanced.
// - After the 12 writes (show_ptr=1, AB), browse 12 times -> A2,A3,...,A9,AA,AB,A2,A3 (wrap checked).
// - Assert reset while holding data, then browse -> all 00; next write lands in slot 0.
// - With STASH_FILL_COUNT_EN: fill_count counts 1..10, stays 10 after 12 writes, reads 0 after reset.

Source files
------------

// File: rtl/stash_pkg.sv
// Shared constants and helpers for the sample_stash lap/split memory.
package stash_pkg;

  localparam int SAMPLE_W = 8;

  // Pointer width for a DEPTH-entry circular store.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stash_ptr_wrap.sv
// Modulo-DEPTH pointer register with synchronous clear, load and increment.
module stash_ptr_wrap
  import stash_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] ptr_inc
);

  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr     = ptr_q;
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  // NOTE: ptr_d is given its hold value first so no path through this block infers a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (load)     ptr_d = load_val;
    else if (inc) ptr_d = ptr_inc;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sample_stash.sv
// Circular store of the last DEPTH samples with a browse pointer and registered display output.
// Optional fill_count output is enabled by defining STASH_FILL_COUNT_EN.
module sample_stash
  import stash_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_in_valid,
  input  logic                next_sample,
  output logic [SAMPLE_W-1:0] sample_out
`ifdef STASH_FILL_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] fill_count
`endif
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]       wr_ptr, wr_inc_unused, show_ptr, show_inc;
  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] mem_d [DEPTH];
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;

  stash_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (sample_in_valid),
    .ptr      (wr_ptr),
    .ptr_inc  (wr_inc_unused)
  );

  // A write snaps the display to the slot just written; browse only when no write.
  stash_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_show_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (sample_in_valid),
    .load_val (wr_ptr),
    .inc      (next_sample),
    .ptr      (show_ptr),
    .ptr_inc  (show_inc)
  );

  always_comb begin
    mem_d        = mem_q;
    sample_out_d = sample_out_q;
    if (sample_in_valid) begin
      mem_d[wr_ptr] = sample_in;
      sample_out_d  = sample_in;
    end else if (next_sample) begin
      sample_out_d  = mem_q[show_inc];
    end
  end

  // NOTE: the memory is a reset-clearable register array, so a reset discards every stored lap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sample_out_q <= '0;
    end else begin
      mem_q        <= mem_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;

`ifdef STASH_FILL_COUNT_EN
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [FW-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (sample_in_valid && fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) fill_q <= '0;
    else       fill_q <= fill_d;
  end

  assign fill_count = fill_q;
`endif

endmodule

// File: tb/tb_sample_stash.sv
// Directed, table-driven bench for sample_stash (DEPTH=10); fill_count checked when STASH_FILL_COUNT_EN is defined.
module tb_sample_stash;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;
  logic [7:0] sample_out;
`ifdef STASH_FILL_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] fill_count;
`endif

  sample_stash #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .next_sample     (next_sample),
    .sample_out      (sample_out)
`ifdef STASH_FILL_COUNT_EN
    ,
    .fill_count      (fill_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic       n;
    logic [7:0] d;
    logic [7:0] exp;
    int         exp_fill;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   fill_model = 0;
  int   checks     = 0;
  int   failures   = 0;

  task automatic push(input logic rst, input logic v, input logic n,
                      input logic [7:0] d, input logic [7:0] exp, input string name);
    vec_t t;
    if (rst)                            fill_model = 0;
    else if (v && fill_model < DEPTH)   fill_model = fill_model + 1;
    t.rst = rst; t.v = v; t.n = n; t.d = d; t.exp = exp;
    t.exp_fill = fill_model; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s step=%0d got=%02h expected=%02h", name, idx, actual, expected);
    end
  endtask

  initial begin
    logic [7:0] browse_exp [12];
    browse_exp = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                   8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hA2, 8'hA3};

    // Reset, then browse an empty store: every slot reads 00.
    for (int i = 0; i < 3; i++)  push(1, 0, 0, 8'h00, 8'h00, "reset");
    for (int i = 0; i < 10; i++) push(0, 0, 1, 8'h00, 8'h00, "browse_empty");

    // Twelve writes, one per two cycles; the third also raises next_sample.
    for (int k = 0; k < 12; k++) begin
      push(0, 1, (k == 2), 8'hA0 + 8'(k), 8'hA0 + 8'(k), "write");
      push(0, 0, 0, 8'h00, 8'hA0 + 8'(k), "hold");
    end

    // show_ptr sits on slot 1; browsing wraps through slot 9 back to 0.
    for (int k = 0; k < 12; k++) push(0, 0, 1, 8'h00, browse_exp[k], "browse_wrap");

    // Reset wins over a concurrent write and clears every slot.
    push(1, 1, 0, 8'hFF, 8'h00, "reset_mid");
    for (int i = 0; i < 10; i++) push(0, 0, 1, 8'h00, 8'h00, "browse_cleared");

    // First write after reset lands in slot 0: nine empty slots, then it reappears.
    push(0, 1, 0, 8'h5A, 8'h5A, "write_slot0");
    for (int i = 0; i < 9; i++) push(0, 0, 1, 8'h00, 8'h00, "browse_after5a");
    push(0, 0, 1, 8'h00, 8'h5A, "wrap_slot0");

    // Write+browse together: display must stay on slot 1, so slot 0 shows on the 9th browse.
    push(0, 1, 1, 8'h6B, 8'h6B, "write_with_next");
    for (int i = 0; i < 8; i++) push(0, 0, 1, 8'h00, 8'h00, "browse_after6b");
    push(0, 0, 1, 8'h00, 8'h5A, "reach_slot0");
    push(0, 0, 1, 8'h00, 8'h6B, "reach_slot1");
    push(0, 0, 0, 8'h00, 8'h6B, "final_hold");

    reset = 1'b1; sample_in = '0; sample_in_valid = 1'b0; next_sample = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      sample_in_valid = vecs[i].v;
      next_sample     = vecs[i].n;
      sample_in       = vecs[i].d;
      @(posedge clk);
      #1;
      check(vecs[i].name, i, int'(sample_out), int'(vecs[i].exp));
`ifdef STASH_FILL_COUNT_EN
      check({vecs[i].name, "_fill"}, i, int'(fill_count), vecs[i].exp_fill);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
